adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_2bit.sv | 12 +
 rtl/adder_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential 2-bit-per-cycle adder: FSM encodings
// and the default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/adder_2bit.sv
// Combinational 2-bit ripple adder slice used once per CALC cycle.
module adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequential adder: consumes two operand bits per cycle through one adder_2bit.
// Optional macro ADDER_SEQ_SAT_EN saturates the sum to all-ones on carry-out.
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH / 2) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH / 2 - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
        $error("adder_seq_ctrl: WIDTH must be even and >= 2");
    end

    adder_state_t     state;
    adder_state_t     state_next;
    logic [WIDTH-1:0] op_one;
    logic [WIDTH-1:0] op_two;
    logic             carry_reg;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic [1:0]       add_sum;
    logic             add_cout;
    logic             last_step;

    adder_2bit u_adder_2bit (
        .a    (op_one[1:0]),
        .b    (op_two[1:0]),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_step = (step_cnt == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result bits enter from the MSB end, so after WIDTH/2 steps the first
    // (least significant) pair has reached bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_one    <= '0;
            op_two    <= '0;
            carry_reg <= 1'b0;
            step_cnt  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_one    <= din_one;
                        op_two    <= din_two;
                        carry_reg <= cin;
                        step_cnt  <= '0;
                    end
                end
                CALC: begin
                    op_one    <= op_one >> 2;
                    op_two    <= op_two >> 2;
                    carry_reg <= add_cout;
                    step_cnt  <= step_cnt + CNT_W'(1);
                    sum_reg   <= WIDTH'({add_sum, sum_reg} >> 2);
                    if (last_step) begin
                        cout_reg <= add_cout;
`ifdef ADDER_SEQ_SAT_EN
                        if (add_cout) begin
                            sum_reg <= '1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl at WIDTH=8; expected values
// follow ADDER_SEQ_SAT_EN when the bench is built with it.
module tb_adder_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din_one;
    logic [7:0] din_two;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;

    int tests_run;
    int fail_count;
    int lat;

    adder_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_one   (din_one),
        .din_two   (din_two),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        in_valid = 1'b1;
        din_one  = a;
        din_two  = b;
        cin      = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runAdd(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int cycles;
        out_ready = 1'b0;
        applyStimulus(a, b, c);
        waitValid(cycles);
        checkOutput({tag, "_latency"}, cycles, 4);
        checkOutput({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_idle_valid"}, {31'd0, out_valid}, 0);
        checkOutput({tag, "_idle_sum"}, {24'd0, sum}, {24'd0, exp_sum});
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        din_one    = '0;
        din_two    = '0;
        cin        = 1'b0;

        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_sum", {24'd0, sum}, 0);
        checkOutput("rst_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runAdd("5a_a5", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
`ifdef ADDER_SEQ_SAT_EN
        runAdd("ff_01", 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b1);
`else
        runAdd("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`endif
        runAdd("00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        runAdd("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Stall in DONE while poking new operands; result must not move.
        applyStimulus(8'h21, 8'h43, 1'b0);
        waitValid(lat);
        checkOutput("stall_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            din_one  = 8'hEE;
            din_two  = 8'h77;
            cin      = 1'b1;
            @(negedge clk);
            checkOutput("stall_sum", {24'd0, sum}, 32'h64);
            checkOutput("stall_cout", {31'd0, cout}, 0);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 0);
            checkOutput("stall_valid", {31'd0, out_valid}, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("stall_release_ready", {31'd0, in_ready}, 1);

        // Reset during the second CALC cycle.
        applyStimulus(8'h99, 8'h11, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, out_valid}, 0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 1);
        checkOutput("midrst_sum", {24'd0, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runAdd("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Back-to-back with both handshakes held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din_one   = 8'h80;
        din_two   = 8'h80;
        cin       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        din_one = 8'h01;
        din_two = 8'h02;
        waitValid(lat);
        checkOutput("b2b_first_latency", lat, 4);
`ifdef ADDER_SEQ_SAT_EN
        checkOutput("b2b_first_sum", {24'd0, sum}, 32'hFF);
`else
        checkOutput("b2b_first_sum", {24'd0, sum}, 32'h00);
`endif
        checkOutput("b2b_first_cout", {31'd0, cout}, 1);
        @(negedge clk);
        checkOutput("b2b_idle_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        checkOutput("b2b_second_accept", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("b2b_second_latency", lat, 4);
        checkOutput("b2b_second_sum", {24'd0, sum}, 32'h03);
        checkOutput("b2b_second_cout", {31'd0, cout}, 0);
        @(negedge clk);
        checkOutput("b2b_end_valid", {31'd0, out_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
